// File: rtl/lut_access_ctrl_pkg.sv
// lut_access_ctrl_pkg: shared types, defaults and helpers for the lookup-table access controller
package lut_access_ctrl_pkg;
  localparam int DEF_NUM_RX = 4;
  localparam int DEF_ASIZE = 8;
  localparam int DEF_DWIDTH = 16;
  localparam int DEF_HOST_MAX_BURST = 4;
  function automatic int lut_depth(input int asize);
    return 1 << asize;
  endfunction
  localparam int LUT_DEPTH = lut_depth(DEF_ASIZE);
  typedef struct packed {
    logic [DEF_NUM_RX-1:0] forward_ports;
    logic [DEF_DWIDTH-DEF_NUM_RX-1:0] vpi;
  } cell_cfg_t;
  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/lut_access_ctrl_if.sv
// lut_access_ctrl_if: host write, Rx lookup and table-side signals of the access controller
interface lut_access_ctrl_if
  import lut_access_ctrl_pkg::*;
#(
  parameter int NUM_RX = DEF_NUM_RX,
  parameter int ASIZE = DEF_ASIZE,
  parameter int DWIDTH = DEF_DWIDTH
);
  logic host_wr_valid;
  logic host_wr_ready;
  logic [ASIZE-1:0] host_wr_addr;
  logic [DWIDTH-1:0] host_wr_data;
  logic [NUM_RX-1:0] rx_req_valid;
  logic [NUM_RX-1:0] rx_req_ready;
  logic [NUM_RX*ASIZE-1:0] rx_req_addr;
  logic [NUM_RX-1:0] rx_rsp_valid;
  logic [DWIDTH-1:0] rx_rsp_data;
  logic lut_we;
  logic lut_re;
  logic [ASIZE-1:0] lut_addr;
  logic [DWIDTH-1:0] lut_wdata;
  logic [DWIDTH-1:0] lut_rdata;
  logic init_done;
  modport master (
    output host_wr_valid, host_wr_addr, host_wr_data, rx_req_valid, rx_req_addr, lut_rdata,
    input host_wr_ready, rx_req_ready, rx_rsp_valid, rx_rsp_data, lut_we, lut_re, lut_addr,
    lut_wdata, init_done
  );
  modport slave (
    input host_wr_valid, host_wr_addr, host_wr_data, rx_req_valid, rx_req_addr, lut_rdata,
    output host_wr_ready, rx_req_ready, rx_rsp_valid, rx_rsp_data, lut_we, lut_re, lut_addr,
    lut_wdata, init_done
  );
endinterface

// File: rtl/lut_access_ctrl_rr_arbiter.sv
// lut_access_ctrl_rr_arbiter: round-robin one-hot arbiter whose search starts at a rotating pointer
module lut_access_ctrl_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] c;
  logic found;
  // first requester at or after the pointer, wrapping around
  always_comb begin
    idx = ptr;
    c = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = PW'((int'(ptr) + k) % N);
      if (!found && req[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
    grant = (en && found) ? N'(1) << idx : '0;
  end
  // pointer moves just past the winner; unchanged when nothing is granted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else ptr <= (en && found) ? PW'((int'(idx) + 1) % N) : ptr;
endmodule

// File: rtl/lut_access_ctrl.sv
// lut_access_ctrl: clears the shared lookup table after reset, then grants one host write or Rx read per cycle
module lut_access_ctrl
  import lut_access_ctrl_pkg::*;
#(
  parameter int NUM_RX = DEF_NUM_RX,
  parameter int ASIZE = DEF_ASIZE,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int HOST_MAX_BURST = DEF_HOST_MAX_BURST
) (
  input logic clk,
  input logic rst_n,
  lut_access_ctrl_if.slave bus
);
  localparam int BW = $clog2(HOST_MAX_BURST + 1);
  state_t state, state_nxt;
  logic [ASIZE-1:0] init_addr;
  logic [ASIZE-1:0] addr_q;
  logic [ASIZE-1:0] rx_addr;
  logic [DWIDTH-1:0] wdata_q;
  logic [BW-1:0] burst;
  logic [NUM_RX-1:0] rx_gnt;
  logic run, rx_any, host_gnt, init_we;
  assign run = state == RUN;
  assign rx_any = |bus.rx_req_valid;
  assign host_gnt = run && bus.host_wr_valid && !(rx_any && burst == BW'(HOST_MAX_BURST));
  lut_access_ctrl_rr_arbiter #(.N(NUM_RX)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(bus.rx_req_valid),
    .en(run && !host_gnt),
    .grant(rx_gnt)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nxt;
  // leave INIT once the last table address has been cleared; RUN is only left through reset
  always_comb
    state_nxt = (state == INIT && init_addr == ASIZE'(lut_depth(ASIZE) - 1)) ? RUN : state;
  // clear counter, host burst counter, held table bus values and registered response strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      init_addr <= '0;
      burst <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      bus.rx_rsp_valid <= '0;
    end else begin
      init_addr <= run ? init_addr : init_addr + 1'b1;
      burst <= (host_gnt && rx_any) ? burst + 1'b1 : (|rx_gnt || !rx_any) ? '0 : burst;
      addr_q <= bus.lut_addr;
      wdata_q <= bus.lut_wdata;
      bus.rx_rsp_valid <= rx_gnt;
    end
  // address of the granted Rx requester
  always_comb begin
    rx_addr = '0;
    for (int i = 0; i < NUM_RX; i++)
      rx_addr = rx_addr | (rx_gnt[i] ? bus.rx_req_addr[i*ASIZE +: ASIZE] : '0);
  end
  // grants and table mux; address and write data hold their last values on idle cycles
  always_comb begin
    init_we = state == INIT && rst_n;
    bus.host_wr_ready = host_gnt;
    bus.rx_req_ready = rx_gnt;
    bus.lut_we = init_we || host_gnt;
    bus.lut_re = |rx_gnt;
    bus.lut_addr = init_we ? init_addr : host_gnt ? bus.host_wr_addr : |rx_gnt ? rx_addr : addr_q;
    bus.lut_wdata = init_we ? '0 : host_gnt ? bus.host_wr_data : wdata_q;
    bus.rx_rsp_data = bus.lut_rdata;
    bus.init_done = run;
  end
endmodule

// File: tb/tb_lut_access_ctrl.sv
// tb_lut_access_ctrl: directed checks of table clear, host/Rx arbitration, read latency and reset recovery
module tb_lut_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] mem [256];
  lut_access_ctrl_if bus ();
  lut_access_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // single-port table: write or read, read data one cycle after lut_re
  always @(posedge clk) begin
    if (bus.lut_we) mem[bus.lut_addr] <= bus.lut_wdata;
    if (bus.lut_re) bus.lut_rdata <= mem[bus.lut_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr = 8'h12;
    bus.host_wr_data = 16'hA5C3;
    bus.rx_req_valid = 4'b0000;
    bus.rx_req_addr = 32'h0;
    @(negedge clk);
    chk("rst_init_done", 32'(bus.init_done), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rx_rsp_valid), 32'h0);
    chk("rst_host_ready", 32'(bus.host_wr_ready), 32'h0);
    chk("rst_we", 32'(bus.lut_we), 32'h0);
    chk("rst_re", 32'(bus.lut_re), 32'h0);
    nxt;
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      chk("init_we", 32'(bus.lut_we), 32'h1);
      chk("init_addr", 32'(bus.lut_addr), k);
      chk("init_wdata", 32'(bus.lut_wdata), 32'h0);
      chk("init_host_ready", 32'(bus.host_wr_ready), 32'h0);
      chk("init_done_low", 32'(bus.init_done), 32'h0);
      nxt;
    end
    @(negedge clk);
    chk("init_done", 32'(bus.init_done), 32'h1);
    chk("wr_ready", 32'(bus.host_wr_ready), 32'h1);
    chk("wr_addr", 32'(bus.lut_addr), 32'h12);
    chk("wr_data", 32'(bus.lut_wdata), 32'hA5C3);
    nxt;
    bus.host_wr_valid = 1'b0;
    bus.rx_req_valid = 4'b0001;
    bus.rx_req_addr = 32'h0000_0012;
    @(negedge clk);
    chk("rd_ready", 32'(bus.rx_req_ready), 32'h1);
    chk("rd_re", 32'(bus.lut_re), 32'h1);
    chk("rd_we", 32'(bus.lut_we), 32'h0);
    chk("rd_addr", 32'(bus.lut_addr), 32'h12);
    nxt;
    bus.rx_req_valid = 4'b0000;
    @(negedge clk);
    chk("rsp_valid", 32'(bus.rx_rsp_valid), 32'h1);
    chk("rsp_data", 32'(bus.rx_rsp_data), 32'hA5C3);
    chk("idle_re", 32'(bus.lut_re), 32'h0);
    chk("idle_we", 32'(bus.lut_we), 32'h0);
    chk("idle_addr_hold", 32'(bus.lut_addr), 32'h12);
    nxt;
    for (int i = 0; i < 4; i++) begin
      bus.host_wr_valid = 1'b1;
      bus.host_wr_addr = 8'(32'h20 + i);
      bus.host_wr_data = 16'(32'h1000 + i);
      @(negedge clk);
      chk("pre_host_ready", 32'(bus.host_wr_ready), 32'h1);
      nxt;
    end
    bus.host_wr_valid = 1'b0;
    bus.rx_req_valid = 4'b1111;
    bus.rx_req_addr = 32'h2322_2120;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.rx_req_ready), 32'(1 << ((k + 1) % 4)));
      chk("rr_addr", 32'(bus.lut_addr), 32'h20 + 32'((k + 1) % 4));
      if (k > 0) begin
        chk("rr_rsp_valid", 32'(bus.rx_rsp_valid), 32'(1 << (k % 4)));
        chk("rr_rsp_data", 32'(bus.rx_rsp_data), 32'h1000 + 32'(k % 4));
      end
      nxt;
    end
    bus.rx_req_valid = 4'b0000;
    @(negedge clk);
    chk("rr_last_rsp_valid", 32'(bus.rx_rsp_valid), 32'h1);
    chk("rr_last_rsp_data", 32'(bus.rx_rsp_data), 32'h1000);
    nxt;
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr = 8'h40;
    bus.host_wr_data = 16'hBEEF;
    bus.rx_req_valid = 4'b0100;
    bus.rx_req_addr = 32'h0041_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("sg_host_ready", 32'(bus.host_wr_ready), 32'h1);
      chk("sg_rx_ready_low", 32'(bus.rx_req_ready), 32'h0);
      nxt;
    end
    @(negedge clk);
    chk("sg_host_blocked", 32'(bus.host_wr_ready), 32'h0);
    chk("sg_rx2_grant", 32'(bus.rx_req_ready), 32'h4);
    chk("sg_rx2_addr", 32'(bus.lut_addr), 32'h41);
    nxt;
    bus.rx_req_valid = 4'b0000;
    @(negedge clk);
    chk("sg_host_resume", 32'(bus.host_wr_ready), 32'h1);
    chk("sg_rsp_valid", 32'(bus.rx_rsp_valid), 32'h4);
    chk("sg_rsp_data", 32'(bus.rx_rsp_data), 32'h0);
    nxt;
    bus.host_wr_valid = 1'b0;
    bus.rx_req_valid = 4'b0010;
    bus.rx_req_addr = 32'h0000_1200;
    @(negedge clk);
    chk("mr_grant", 32'(bus.rx_req_ready), 32'h2);
    rst_n = 1'b0;
    bus.rx_req_valid = 4'b0000;
    nxt;
    chk("mr_no_rsp", 32'(bus.rx_rsp_valid), 32'h0);
    chk("mr_ready_low", 32'(bus.rx_req_ready), 32'h0);
    chk("mr_done_low", 32'(bus.init_done), 32'h0);
    nxt;
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      chk("re_init_addr", 32'(bus.lut_addr), k);
      chk("re_init_done_low", 32'(bus.init_done), 32'h0);
      nxt;
    end
    @(negedge clk);
    chk("re_init_done", 32'(bus.init_done), 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
